rc5_key_expander: RTL

RC5_KEY_EXPANDER -- requirements
Module: rc5_key_expander

---
 rtl/rc5_key_expander.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/rc5_key_expander.sv
// RC5 key schedule engine: fills the S table from a byte-wide key RAM,
// using external single-port L and S RAMs with registered read data.
module rc5_key_expander #(
  parameter int             W  = 16,
  parameter int             B  = 16,
  parameter int             R  = 12,
  parameter int             C  = B / (W / 8),
  parameter logic [W-1:0]   PW = 16'hb7e1,
  parameter logic [W-1:0]   QW = 16'h9e37
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iStart,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oKeyReady,
  output logic [$clog2(B)-1:0]          oKey_address,
  input  logic [7:0]                    iKey_sub_i,
  output logic [$clog2(C)-1:0]          oL_address,
  output logic [W-1:0]                  oL_data,
  output logic                          oL_wen,
  input  logic [W-1:0]                  iL_data,
  output logic [$clog2(2*R+2)-1:0]      oS_address,
  output logic [W-1:0]                  oS_data,
  output logic                          oS_wen,
  input  logic [W-1:0]                  iS_data
);

  // Derived sizes.
  localparam int U   = W / 8;
  localparam int T   = 2 * R + 2;
  localparam int N   = 3 * ((T > C) ? T : C);
  localparam int KAW = $clog2(B);
  localparam int LAW = $clog2(C);
  localparam int SAW = $clog2(T);
  localparam int CNW = $clog2(N);
  localparam int BCW = $clog2(U + 1);
  localparam int RW  = $clog2(W);

  localparam logic [SAW-1:0] I_LAST   = SAW'(T - 1);
  localparam logic [LAW-1:0] J_LAST   = LAW'(C - 1);
  localparam logic [CNW-1:0] CNT_LAST = CNW'(N - 1);
  localparam logic [BCW-1:0] BYTE_WR  = BCW'(U);

  typedef enum logic [2:0] {
    IDLE,
    INIT_S,
    LOAD_L,
    MIX_RD,
    MIX_S,
    MIX_L,
    DONE
  } state_e;

  // Rotate left by s bits; the doubled word makes s == 0 fall out naturally.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] s);
    logic [2*W-1:0] t;
    t = {x, x} << s;
    return t[2*W-1:W];
  endfunction

  state_e           state_q, state_d;
  logic [SAW-1:0]   i_q, i_d;          // S index (also the INIT_S write counter)
  logic [LAW-1:0]   j_q, j_d;          // L index (also the LOAD_L word counter)
  logic [BCW-1:0]   byte_q, byte_d;    // byte phase within one L word load
  logic [CNW-1:0]   cnt_q, cnt_d;      // mixing iteration counter
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     s_val_q, s_val_d;  // running P + k*Q during INIT_S
  logic [W-9:0]     acc_q, acc_d;      // lower key bytes of the word being assembled
  logic             key_ready_q, key_ready_d;

  logic [W-1:0]     ab_sum;
  logic [W-1:0]     a_new;
  logic [W-1:0]     b_new;
  logic [W-1:0]     l_word;
  logic [KAW-1:0]   key_addr;

  // Mixing datapath: A uses the S word read back, B uses the freshly updated A.
  assign ab_sum   = a_q + b_q;
  assign a_new    = rotl(iS_data + ab_sum, RW'(3));
  assign b_new    = rotl(iL_data + ab_sum, ab_sum[RW-1:0]);
  // Newest byte lands on top, so after U shifts byte 0 sits in bits [7:0].
  assign l_word   = {iKey_sub_i, acc_q};
  assign key_addr = KAW'(32'(j_q) * U + 32'(byte_q));

  assign oBusy     = (state_q != IDLE);
  assign oKeyReady = key_ready_q;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      byte_q      <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_val_q     <= '0;
      acc_q       <= '0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_val_q     <= s_val_d;
      acc_q       <= acc_d;
      key_ready_q <= key_ready_d;
    end
  end

  // Next-state logic and RAM port control; outputs idle at zero by default.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    byte_d       = byte_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    s_val_d      = s_val_q;
    acc_d        = acc_q;
    key_ready_d  = key_ready_q;
    oDone        = 1'b0;
    oKey_address = '0;
    oL_address   = '0;
    oL_data      = '0;
    oL_wen       = 1'b0;
    oS_address   = '0;
    oS_data      = '0;
    oS_wen       = 1'b0;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d     = INIT_S;
          key_ready_d = 1'b0;
          i_d         = '0;
          s_val_d     = PW;
        end
      end

      INIT_S: begin
        oS_address = i_q;
        oS_data    = s_val_q;
        oS_wen     = 1'b1;
        s_val_d    = s_val_q + QW;
        if (i_q == I_LAST) begin
          i_d     = '0;
          j_d     = '0;
          byte_d  = '0;
          state_d = LOAD_L;
        end else begin
          i_d = i_q + SAW'(1);
        end
      end

      LOAD_L: begin
        if (byte_q == BYTE_WR) begin
          // Last byte arrives this cycle straight from the key RAM.
          oL_address = j_q;
          oL_data    = l_word;
          oL_wen     = 1'b1;
          byte_d     = '0;
          if (j_q == J_LAST) begin
            j_d     = '0;
            i_d     = '0;
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
            state_d = MIX_RD;
          end else begin
            j_d = j_q + LAW'(1);
          end
        end else begin
          // The first shift captures stale data; it is pushed out before the write.
          oKey_address = key_addr;
          acc_d        = l_word[W-1:8];
          byte_d       = byte_q + BCW'(1);
        end
      end

      MIX_RD: begin
        oS_address = i_q;
        oL_address = j_q;
        state_d    = MIX_S;
      end

      MIX_S: begin
        // L address held so its read data is valid in MIX_L.
        oS_address = i_q;
        oS_data    = a_new;
        oS_wen     = 1'b1;
        oL_address = j_q;
        a_d        = a_new;
        state_d    = MIX_L;
      end

      MIX_L: begin
        oL_address = j_q;
        oL_data    = b_new;
        oL_wen     = 1'b1;
        b_d        = b_new;
        i_d        = (i_q == I_LAST) ? '0 : i_q + SAW'(1);
        j_d        = (j_q == J_LAST) ? '0 : j_q + LAW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNW'(1);
          state_d = MIX_RD;
        end
      end

      DONE: begin
        oDone       = 1'b1;
        key_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
